// File: rtl/control_sequencer.sv
// Microcode control unit: steps T0..T4, decodes opcode and flags into the 16-bit bus control word.
// Optional macro SEQ_EARLY_END_EN ends each instruction after its last non-empty step.
module control_sequencer #(
   parameter int STEPS = 5
) (
   input  logic        clk,
   input  logic        clear,
   input  logic [3:0]  opcode,
   input  logic        carry,
   input  logic        zero,
   output logic [15:0] ctrl,
   output logic [2:0]  step,
   output logic        halted
);

   localparam logic [15:0] HLT = 16'h8000;
   localparam logic [15:0] MI  = 16'h4000;
   localparam logic [15:0] RI  = 16'h2000;
   localparam logic [15:0] RO  = 16'h1000;
   localparam logic [15:0] IO  = 16'h0800;
   localparam logic [15:0] II  = 16'h0400;
   localparam logic [15:0] AI  = 16'h0200;
   localparam logic [15:0] AO  = 16'h0100;
   localparam logic [15:0] EO  = 16'h0080;
   localparam logic [15:0] SU  = 16'h0040;
   localparam logic [15:0] BI  = 16'h0020;
   localparam logic [15:0] OI  = 16'h0010;
   localparam logic [15:0] CE  = 16'h0008;
   localparam logic [15:0] CO  = 16'h0004;
   localparam logic [15:0] J   = 16'h0002;
   localparam logic [15:0] FI  = 16'h0001;

   logic [2:0]  step_q, step_d;
   logic        halted_q, halted_d;
   logic [15:0] word_s;
   logic [2:0]  len_s;
   logic        last_s;

   // Microcode decode of the current step into a raw control word.
   always_comb begin
      word_s = 16'h0000;
      case (step_q)
         3'd0: word_s = CO | MI;
         3'd1: word_s = RO | II | CE;
         3'd2: begin
            case (opcode)
               4'h1, 4'h2, 4'h3, 4'h4: word_s = IO | MI;
               4'h5: word_s = IO | AI;
               4'h6: word_s = IO | J;
               4'h7: word_s = carry ? (IO | J) : 16'h0000;
               4'h8: word_s = zero ? (IO | J) : 16'h0000;
               4'hE: word_s = AO | OI;
               4'hF: word_s = HLT;
               default: word_s = 16'h0000;
            endcase
         end
         3'd3: begin
            case (opcode)
               4'h1: word_s = RO | AI;
               4'h2: word_s = RO | BI;
               4'h3: word_s = RO | BI | SU;
               4'h4: word_s = AO | RI;
               default: word_s = 16'h0000;
            endcase
         end
         3'd4: begin
            case (opcode)
               4'h2: word_s = EO | AI | FI;
               4'h3: word_s = EO | AI | FI | SU;
               default: word_s = 16'h0000;
            endcase
         end
         default: word_s = 16'h0000;
      endcase
   end

   // Number of steps the current instruction occupies.
   always_comb begin
      len_s = 3'd2;
      case (opcode)
         4'h1, 4'h4:             len_s = 3'd4;
         4'h2, 4'h3:             len_s = 3'd5;
         4'h5, 4'h6, 4'hE, 4'hF: len_s = 3'd3;
         4'h7:                   len_s = carry ? 3'd3 : 3'd2;
         4'h8:                   len_s = zero ? 3'd3 : 3'd2;
         default:                len_s = 3'd2;
      endcase
   end

`ifdef SEQ_EARLY_END_EN
   assign last_s = (step_q == (len_s - 3'd1)) || (step_q == 3'(STEPS - 1));
`else
   assign last_s = (step_q == 3'(STEPS - 1));
`endif

   // Output gating: clear blanks the bus, halt leaves only the hlt strobe.
   always_comb begin
      ctrl = 16'h0000;
      if (clear) begin
         ctrl = 16'h0000;
      end else if (halted_q) begin
         ctrl = HLT;
      end else begin
         ctrl = word_s;
      end
   end

   // Next-state: a halting step freezes the counter where it is.
   always_comb begin
      step_d   = step_q;
      halted_d = halted_q;
      if (clear) begin
         step_d   = 3'd0;
         halted_d = 1'b0;
      end else if (halted_q) begin
         step_d   = step_q;
         halted_d = 1'b1;
      end else if (ctrl[15]) begin
         step_d   = step_q;
         halted_d = 1'b1;
      end else if (last_s) begin
         step_d   = 3'd0;
         halted_d = 1'b0;
      end else begin
         step_d   = step_q + 3'd1;
         halted_d = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      step_q   <= step_d;
      halted_q <= halted_d;
   end

   assign step   = step_q;
   assign halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: vector table, corner sequences and a randomized run
// against a microcode-table reference model (honours SEQ_EARLY_END_EN).
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        clear;
   logic [3:0]  opcode;
   logic        carry;
   logic        zero;
   logic [15:0] ctrl;
   logic [2:0]  step;
   logic        halted;

   int tests = 0;
   int fails = 0;

   logic [15:0] ucode [16][3];
   int          m_step;
   bit          m_halt;

   control_sequencer #(.STEPS(5)) dut (
      .clk(clk), .clear(clear), .opcode(opcode), .carry(carry), .zero(zero),
      .ctrl(ctrl), .step(step), .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic        c;
      logic        z;
      logic [15:0] t2;
      logic [15:0] t3;
      logic [15:0] t4;
      int          elen;
   } vec_t;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int ilen(input logic [3:0] op, input logic c, input logic z);
`ifdef SEQ_EARLY_END_EN
      if (op == 4'h2 || op == 4'h3) return 5;
      if (op == 4'h1 || op == 4'h4) return 4;
      if (op == 4'h5 || op == 4'h6 || op == 4'hE || op == 4'hF) return 3;
      if (op == 4'h7) return c ? 3 : 2;
      if (op == 4'h8) return z ? 3 : 2;
      return 2;
`else
      return 5;
`endif
   endfunction

   function automatic logic [15:0] model_ctrl(input logic [3:0] op, input logic c, input logic z,
                                              input logic clr);
      logic [15:0] w;
      if (clr) return 16'h0000;
      if (m_halt) return 16'h8000;
      if (m_step == 0) return 16'h4004;
      if (m_step == 1) return 16'h1408;
      w = ucode[op][m_step-2];
      if ((op == 4'h7 && !c) || (op == 4'h8 && !z)) w = 16'h0000;
      return w;
   endfunction

   // One clock cycle: drive, check at negedge, advance the model at posedge.
   task automatic cyc(input logic [3:0] op, input logic c, input logic z, input logic clr,
                      output logic [15:0] got_ctrl, output logic [2:0] got_step);
      logic [15:0] exp;
      opcode = op; carry = c; zero = z; clear = clr;
      exp = model_ctrl(op, c, z, clr);
      @(negedge clk);
      got_ctrl = ctrl;
      got_step = step;
      chk("ctrl", ctrl, exp);
      chk("step", {13'd0, step}, m_step[15:0]);
      chk("halted", {15'd0, halted}, {15'd0, m_halt});
      chk("one_bus_driver", {15'd0, ($countones(ctrl & 16'h1984) > 1)}, 16'h0000);
      @(posedge clk);
      if (clr) begin
         m_step = 0; m_halt = 1'b0;
      end else if (m_halt) begin
         m_halt = 1'b1;
      end else if (exp[15]) begin
         m_halt = 1'b1;
      end else if (m_step + 1 >= ilen(op, c, z)) begin
         m_step = 0;
      end else begin
         m_step++;
      end
      #1;
   endtask

   vec_t        vecs[13];
   logic [15:0] g_ctrl;
   logic [2:0]  g_step;
   logic [15:0] exp_tbl [5];
   int          n;

   initial begin
      for (int i = 0; i < 16; i++)
         for (int k = 0; k < 3; k++) ucode[i][k] = 16'h0000;
      ucode[1] = '{16'h4800, 16'h1200, 16'h0000};
      ucode[2] = '{16'h4800, 16'h1020, 16'h0281};
      ucode[3] = '{16'h4800, 16'h1060, 16'h02C1};
      ucode[4] = '{16'h4800, 16'h2100, 16'h0000};
      ucode[5] = '{16'h0A00, 16'h0000, 16'h0000};
      ucode[6] = '{16'h0802, 16'h0000, 16'h0000};
      ucode[7] = '{16'h0802, 16'h0000, 16'h0000};
      ucode[8] = '{16'h0802, 16'h0000, 16'h0000};
      ucode[14] = '{16'h0110, 16'h0000, 16'h0000};
      ucode[15] = '{16'h8000, 16'h0000, 16'h0000};

      vecs[0]  = '{4'h0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 2};
      vecs[1]  = '{4'h1, 1'b0, 1'b0, 16'h4800, 16'h1200, 16'h0000, 4};
      vecs[2]  = '{4'h2, 1'b1, 1'b1, 16'h4800, 16'h1020, 16'h0281, 5};
      vecs[3]  = '{4'h3, 1'b0, 1'b1, 16'h4800, 16'h1060, 16'h02C1, 5};
      vecs[4]  = '{4'h4, 1'b1, 1'b0, 16'h4800, 16'h2100, 16'h0000, 4};
      vecs[5]  = '{4'h5, 1'b0, 1'b0, 16'h0A00, 16'h0000, 16'h0000, 3};
      vecs[6]  = '{4'h6, 1'b0, 1'b0, 16'h0802, 16'h0000, 16'h0000, 3};
      vecs[7]  = '{4'h7, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 2};
      vecs[8]  = '{4'h7, 1'b1, 1'b0, 16'h0802, 16'h0000, 16'h0000, 3};
      vecs[9]  = '{4'h8, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 2};
      vecs[10] = '{4'h8, 1'b0, 1'b1, 16'h0802, 16'h0000, 16'h0000, 3};
      vecs[11] = '{4'hE, 1'b0, 1'b0, 16'h0110, 16'h0000, 16'h0000, 3};
      vecs[12] = '{4'hA, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 2};

      clear = 1'b1; opcode = 4'h0; carry = 1'b0; zero = 1'b0;
      @(posedge clk); #1;
      m_step = 0; m_halt = 1'b0;

      // Reset held two cycles: bus quiet, step 0, not halted.
      for (int i = 0; i < 2; i++) begin
         cyc(4'h0, 1'b0, 1'b0, 1'b1, g_ctrl, g_step);
         chk("reset_ctrl", g_ctrl, 16'h0000);
         chk("reset_step", {13'd0, g_step}, 16'h0000);
      end

      // Vector table: one instruction per entry, fetch plus execute steps.
      foreach (vecs[v]) begin
         exp_tbl = '{16'h4004, 16'h1408, vecs[v].t2, vecs[v].t3, vecs[v].t4};
`ifdef SEQ_EARLY_END_EN
         n = vecs[v].elen;
`else
         n = 5;
`endif
         for (int s = 0; s < n; s++) begin
            cyc(vecs[v].op, vecs[v].c, vecs[v].z, 1'b0, g_ctrl, g_step);
            chk($sformatf("tbl_ctrl op%h s%0d", vecs[v].op, s), g_ctrl, exp_tbl[s]);
            chk($sformatf("tbl_step op%h s%0d", vecs[v].op, s), {13'd0, g_step}, s[15:0]);
         end
      end
      cyc(4'h0, 1'b0, 1'b0, 1'b0, g_ctrl, g_step);
      chk("wrap_to_t0", {13'd0, g_step}, 16'h0000);
      n = ilen(4'h0, 1'b0, 1'b0);
      for (int s = 1; s < n; s++) cyc(4'h0, 1'b0, 1'b0, 1'b0, g_ctrl, g_step);

      // Halt: hlt at T2, then frozen at step 2 with only hlt, released by clear.
      for (int s = 0; s < 3; s++) cyc(4'hF, 1'b0, 1'b0, 1'b0, g_ctrl, g_step);
      chk("hlt_t2", g_ctrl, 16'h8000);
      for (int i = 0; i < 10; i++) begin
         cyc(4'h2, 1'b1, 1'b1, 1'b0, g_ctrl, g_step);
         chk("halt_ctrl", g_ctrl, 16'h8000);
         chk("halt_step", {13'd0, g_step}, 16'h0002);
         chk("halt_flag", {15'd0, halted}, 16'h0001);
      end
      cyc(4'h0, 1'b0, 1'b0, 1'b1, g_ctrl, g_step);
      chk("halt_clear_ctrl", g_ctrl, 16'h0000);
      cyc(4'h0, 1'b0, 1'b0, 1'b0, g_ctrl, g_step);
      chk("after_halt_step", {13'd0, g_step}, 16'h0000);
      chk("after_halt_flag", {15'd0, halted}, 16'h0000);
      chk("after_halt_ctrl", g_ctrl, 16'h4004);
      for (int s = 1; s < ilen(4'h0, 1'b0, 1'b0); s++) cyc(4'h0, 1'b0, 1'b0, 1'b0, g_ctrl, g_step);

      // Clear asserted at T3 of LDA aborts it; next cycle restarts at T0.
      for (int s = 0; s < 3; s++) cyc(4'h1, 1'b0, 1'b0, 1'b0, g_ctrl, g_step);
      cyc(4'h1, 1'b0, 1'b0, 1'b1, g_ctrl, g_step);
      chk("abort_ctrl", g_ctrl, 16'h0000);
      cyc(4'h1, 1'b0, 1'b0, 1'b0, g_ctrl, g_step);
      chk("abort_restart_ctrl", g_ctrl, 16'h4004);
      chk("abort_restart_step", {13'd0, g_step}, 16'h0000);

      // Randomized run: new opcode at each T0, random flags, occasional clear.
      begin
         logic [3:0] rop;
         rop = 4'h1;
         for (int i = 0; i < 600; i++) begin
            if (m_step == 0 && !m_halt) rop = 4'($urandom_range(0, 15));
            cyc(rop, 1'($urandom), 1'($urandom), ($urandom_range(0, 29) == 0), g_ctrl, g_step);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
